// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC multiplexed-bus burst engine.
package rtc_bus_pkg;

  localparam int unsigned RTC_ADDR_W = 8;
  localparam int unsigned DEF_T_SU   = 2;
  localparam int unsigned DEF_T_PW   = 4;
  localparam int unsigned DEF_T_HD   = 2;
  localparam int unsigned TMR_W      = 8;

  typedef enum logic [2:0] {
    IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, FIN
  } state_t;

  function automatic logic is_addr(input state_t s);
    return (s == A_SU) || (s == A_PW) || (s == A_HD);
  endfunction

  function automatic logic is_data(input state_t s);
    return (s == D_SU) || (s == D_PW) || (s == D_HD);
  endfunction

endpackage

// File: rtl/rtc_bus_burst_engine_timer.sv
// Loadable phase down-counter; last is high while the count sits at zero.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/rtc_bus_burst_engine.sv
// Burst sequencer for the RTC address/data multiplexed bus with programmable
// setup/pulse/hold widths and auto-incrementing register address.
module rtc_bus_burst_engine
  import rtc_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned T_SU   = DEF_T_SU,
  parameter int unsigned T_PW   = DEF_T_PW,
  parameter int unsigned T_HD   = DEF_T_HD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              write_not_read,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [CNT_W-1:0]  word_idx,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  state_t             state, next;
  logic               wnr_q;
  logic [CNT_W-1:0]   count_q, idx_n;
  logic [DATA_W-1:0]  addr_q, addr_n, wdata_q, wdata_n;
  logic               tmr_last, tmr_load, capture;
  logic [TMR_W-1:0]   tmr_val;

  rtc_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_comb begin
    next    = state;
    addr_n  = addr_q;
    idx_n   = word_idx;
    wdata_n = wdata_q;
    tmr_val = '0;
    unique case (state)
      IDLE: if (start) begin
        next   = (count == '0) ? FIN : A_SU;
        addr_n = base_addr;
        idx_n  = '0;
      end
      A_SU: if (tmr_last) next = A_PW;
      A_PW: if (tmr_last) next = A_HD;
      A_HD: if (tmr_last) begin
        next    = D_SU;
        wdata_n = wr_data;
      end
      D_SU: if (tmr_last) next = D_PW;
      D_PW: if (tmr_last) next = D_HD;
      D_HD: if (tmr_last) begin
        if (word_idx == count_q - CNT_W'(1)) begin
          next = FIN;
        end else begin
          next   = A_SU;
          addr_n = addr_q + DATA_W'(1);
          idx_n  = word_idx + CNT_W'(1);
        end
      end
      default: next = IDLE;
    endcase
    unique case (next)
      A_SU, D_SU: tmr_val = TMR_W'(T_SU - 1);
      A_PW, D_PW: tmr_val = TMR_W'(T_PW - 1);
      A_HD, D_HD: tmr_val = TMR_W'(T_HD - 1);
      default:    tmr_val = '0;
    endcase
  end

  // Every state change is a phase entry, so the timer reloads exactly then.
  assign tmr_load = (next != state);
  assign capture  = (state == D_PW) && tmr_last && !wnr_q;

  // Pad outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wnr_q    <= 1'b0;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_idx <= '0;
      bus_out  <= '0;
      bus_oe   <= 1'b0;
      a_d      <= 1'b1;
      cs       <= 1'b1;
      rd       <= 1'b1;
      wr       <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= next;
      addr_q   <= addr_n;
      word_idx <= idx_n;
      wdata_q  <= wdata_n;
      if (state == IDLE && start) begin
        wnr_q   <= write_not_read;
        count_q <= count;
      end
      rd_valid <= capture;
      if (capture) rd_data <= bus_in;
      cs       <= !(is_addr(next) || is_data(next));
      a_d      <= !is_addr(next);
      wr       <= !((next == A_PW) || ((next == D_PW) && wnr_q));
      rd       <= !((next == D_PW) && !wnr_q);
      bus_oe   <= is_addr(next) || (is_data(next) && wnr_q);
      bus_out  <= is_addr(next) ? addr_n : (is_data(next) ? wdata_n : '0);
      busy     <= is_addr(next) || is_data(next);
      done     <= (next == FIN);
    end
  end

endmodule

// File: tb/tb_rtc_bus_burst_engine.sv
// Scoreboard bench for rtc_bus_burst_engine: strobes, read words and done timing.
module tb_rtc_bus_burst_engine;

  localparam int unsigned P = 16;

  typedef struct packed {
    logic       is_rd;
    logic       ad;
    logic       oe;
    logic [7:0] bus;
    logic [7:0] len;
  } strobe_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } rdexp_t;

  logic       clk = 1'b0;
  logic       reset, start, start2, write_not_read;
  logic [7:0] base_addr, wr_data, bus_in, wbase, tb_addr;
  logic [3:0] count;
  logic [7:0] bus_out, rd_data, bus_out2, rd_data2;
  logic [3:0] word_idx, word_idx2;
  logic       bus_oe, a_d, cs, rd, wr, rd_valid, busy, done;
  logic       bus_oe2, a_d2, cs2, rd2, wr2, rd_valid2, busy2, done2;

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned cyc = 0, t0 = 0, t0_2 = 0, cs_low_cnt = 0, strobes2 = 0;
  logic        exp_wnr = 1'b1, fast_done_seen = 1'b0;

  strobe_t     strobe_q[$];
  rdexp_t      rd_q[$];
  int unsigned done_q[$];

  rtc_bus_burst_engine #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .write_not_read(write_not_read),
    .base_addr(base_addr), .count(count), .wr_data(wr_data), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .word_idx(word_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done)
  );

  rtc_bus_burst_engine #(.DATA_W(8), .CNT_W(4), .T_SU(1), .T_PW(1), .T_HD(1)) dut_fast (
    .clk(clk), .reset(reset), .start(start2), .write_not_read(write_not_read),
    .base_addr(base_addr), .count(count), .wr_data(wr_data), .bus_in(bus_in),
    .bus_out(bus_out2), .bus_oe(bus_oe2), .a_d(a_d2), .cs(cs2), .rd(rd2), .wr(wr2),
    .word_idx(word_idx2), .rd_valid(rd_valid2), .rd_data(rd_data2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  assign wr_data = wbase ^ {4'h0, word_idx};
  assign bus_in  = tb_addr ^ 8'hA5;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_burst(input logic wnr, input logic [7:0] base, input logic [3:0] n,
                            input logic [7:0] wb);
    logic [7:0] a;
    for (int unsigned i = 0; i < n; i++) begin
      a = base + 8'(i);
      strobe_q.push_back({1'b0, 1'b0, 1'b1, a, 8'd4});
      if (wnr) strobe_q.push_back({1'b0, 1'b1, 1'b1, wb ^ 8'(i), 8'd4});
      else begin
        strobe_q.push_back({1'b1, 1'b1, 1'b0, 8'h00, 8'd4});
        rd_q.push_back({4'(i), a ^ 8'hA5});
      end
    end
    done_q.push_back(1 + int'(n) * P);
  endtask

  task automatic start_burst(input logic wnr, input logic [7:0] base, input logic [3:0] n);
    @(negedge clk);
    write_not_read = wnr; base_addr = base; count = n; exp_wnr = wnr;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (done_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain_done_q", done_q.size(), 0);
    check("drain_strobe_q", strobe_q.size(), 0);
    check("drain_rd_q", rd_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RTC bus model: remembers the latched address and answers address ^ 8'hA5.
  initial begin
    tb_addr = '0;
    forever begin
      @(negedge clk);
      if (!cs && !a_d) tb_addr = bus_out;
    end
  end

  initial begin : mon
    int unsigned run = 0;
    strobe_t s, e;
    rdexp_t r;
    forever begin
      @(negedge clk);
      if (reset) run = 0;
      else begin
        if (!wr || !rd) begin
          run++;
          s = {!rd, a_d, bus_oe, bus_out, 8'd0};
        end else if (run > 0) begin
          if (strobe_q.size() == 0) check("strobe_extra", strobe_q.size(), 1);
          else begin
            e = strobe_q.pop_front();
            check("strobe_kind", {s.is_rd, s.ad, s.oe}, {e.is_rd, e.ad, e.oe});
            if (e.oe) check("strobe_bus", s.bus, e.bus);
            check("strobe_len", run, e.len);
          end
          run = 0;
        end
        if (!cs && a_d) check("data_phase_oe", bus_oe, exp_wnr);
        if (!cs) cs_low_cnt++;
        if (rd_valid) begin
          if (rd_q.size() == 0) check("rd_extra", rd_q.size(), 1);
          else begin
            r = rd_q.pop_front();
            check("rd_data", rd_data, r.data);
            check("rd_word_idx", word_idx, r.idx);
          end
        end
        if (done) begin
          check("done_busy", busy, 0);
          if (done_q.size() == 0) check("done_extra", done_q.size(), 1);
          else check("done_cycle", cyc - t0, done_q.pop_front());
        end
      end
    end
  end

  initial begin : mon_fast
    int unsigned run2 = 0;
    forever begin
      @(negedge clk);
      if (reset) run2 = 0;
      else begin
        if (!wr2 || !rd2) run2++;
        else if (run2 > 0) begin
          check("fast_strobe_len", run2, 1);
          strobes2++;
          run2 = 0;
        end
        if (done2) begin
          check("fast_done_cycle", cyc - t0_2, 13);
          fast_done_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    int unsigned n;
    int unsigned cs_snap;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; write_not_read = 1'b0;
    base_addr = '0; count = '0; wbase = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {a_d, cs, rd, wr, bus_oe, busy, done, rd_valid}, 8'b1111_0000);
    check("rst_bus_out", bus_out, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_word_idx", word_idx, 0);
    reset = 1'b0;

    // Single write
    wbase = 8'h45;
    push_burst(1'b1, 8'h21, 4'd1, 8'h45);
    start_burst(1'b1, 8'h21, 4'd1);
    @(negedge clk);
    check("busy_cycle1", busy, 1);
    wait_drain();

    // Read burst of three
    push_burst(1'b0, 8'h21, 4'd3, 8'h00);
    start_burst(1'b0, 8'h21, 4'd3);
    wait_drain();

    // Address wrap
    wbase = 8'h3C;
    push_burst(1'b1, 8'hFF, 4'd2, 8'h3C);
    start_burst(1'b1, 8'hFF, 4'd2);
    wait_drain();

    // Zero-length burst
    cs_snap = cs_low_cnt;
    done_q.push_back(1);
    start_burst(1'b1, 8'h50, 4'd0);
    wait_drain();
    check("zero_cs_low", cs_low_cnt - cs_snap, 0);

    // A second start mid-burst must not disturb the latched burst
    wbase = 8'h5A;
    push_burst(1'b1, 8'h10, 4'd2, 8'h5A);
    start_burst(1'b1, 8'h10, 4'd2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    write_not_read = 1'b0; base_addr = 8'h80; count = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset during the data strobe
    wbase = 8'h77;
    push_burst(1'b1, 8'h30, 4'd1, 8'h77);
    start_burst(1'b1, 8'h30, 4'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_d && !wr && !cs) && n < 100);
    check("reach_d_pw", n < 100, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ctrl", {cs, rd, wr, bus_oe, a_d, done, busy}, 7'b1110100);
    strobe_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_burst(1'b0, 8'h40, 4'd1, 8'h00);
    start_burst(1'b0, 8'h40, 4'd1);
    wait_drain();

    // Minimum timing on the fast instance
    @(negedge clk);
    write_not_read = 1'b1; base_addr = 8'h60; count = 4'd2; start2 = 1'b1;
    t0_2 = cyc;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    while (!fast_done_seen && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check("fast_done_seen", fast_done_seen, 1);
    check("fast_strobe_count", strobes2, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_burst_engine.md
# rtc_bus_burst_engine

Parametrised bus-cycle sequencer for the external RTC's multiplexed address/data bus. It supersedes the fixed single-transfer strobe generator. It accepts one burst request (read or write, base address, word count) and runs back-to-back address and data phases on `a_d`/`cs`/`rd`/`wr`. Per-phase setup, pulse and hold widths are programmable, and the register address auto-increments. It sits between the general configuration FSM and the top-level tri-state buffer on `dato`.

## Interface
Parameters:
- `DATA_W`, 8: bus width; address and data share it.
- `CNT_W`, 4: width of `count`; max burst is 2^CNT_W−1 words.
- `T_SU`, 2: setup cycles per phase, ≥1.
- `T_PW`, 4: strobe-low cycles per phase, ≥1.
- `T_HD`, 2: hold cycles per phase, ≥1.

Ports (one clock; `reset` is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: async active-high reset.
- `start` in 1: burst request, sampled in IDLE.
- `write_not_read` in 1: 1 = write burst, 0 = read burst.
- `base_addr` in DATA_W: first RTC register address.
- `count` in CNT_W: number of words.
- `wr_data` in DATA_W: write word for `word_idx`, combinationally valid.
- `bus_in` in DATA_W: `dato` as seen from the pad.
- `bus_out` out DATA_W: value to drive on `dato`.
- `bus_oe` out 1: tri-state enable for `dato`.
- `a_d` out 1: 0 = address phase, 1 = data phase.
- `cs` out 1: chip select, active-low.
- `rd` out 1: read strobe, active-low.
- `wr` out 1: write strobe, active-low.
- `word_idx` out CNT_W: index of the word in progress.
- `rd_valid` out 1: one-cycle pulse when `rd_data` is valid.
- `rd_data` out DATA_W: captured read word.
- `busy` out 1: a burst is in progress.
- `done` out 1: one-cycle pulse at burst end.

## Operation
- States: IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, FIN.
- IDLE exit on `start`:
  - Latch `write_not_read`, `base_addr` and `count`; clear `word_idx`.
  - If `count`≠0, go to A_SU.
  - If `count`=0, go to FIN; no bus activity.
- Each of the six phase states lasts its parameter's cycle count, then advances A_SU→A_PW→A_HD→D_SU→D_PW→D_HD.
- After D_HD:
  - If `word_idx`=count−1, go to FIN.
  - Otherwise increment `word_idx` and the address, and go to A_SU.
- FIN lasts one cycle, then goes to IDLE.
- Outputs in each state:
  - `cs`=0 in all A_*/D_* states.
  - `a_d`=0 in A_*, 1 in D_*.
  - `wr`=0 in A_PW always, and in D_PW for writes.
  - `rd`=0 in D_PW for reads.
  - `bus_oe`=1 in all A_* states, and in D_* states for writes.
  - `bus_out` = current address in A_*; the write word in D_*.
- The write word is registered from `wr_data` on D_SU entry and held stable through D_HD.
- The address is `base_addr`+`word_idx`, modulo 2^DATA_W; 8'hFF wraps to 8'h00.
- Read capture: `bus_in` is registered into `rd_data` on the last D_PW cycle. `rd_valid` pulses on the following cycle (first D_HD cycle) with that word's `word_idx`.
- `start` while not in IDLE is ignored; latched parameters do not change mid-burst.
- `busy`=1 from the cycle after `start` is accepted through FIN's preceding cycle; `busy`=0 in FIN and IDLE.
- `done`=1 only in FIN.

## Timing
- Reset values: `a_d`=1, `cs`=1, `rd`=1, `wr`=1, `bus_oe`=0, `bus_out`=0, `rd_data`=0, `rd_valid`=0, `busy`=0, `done`=0, `word_idx`=0, state IDLE.
- All outputs are registered; no combinational path from inputs to pads.
- Per word: P = 2·(T_SU+T_PW+T_HD) cycles; 16 at defaults.
- `start` accepted at cycle 0 → A_SU at cycle 1 → `done` at cycle 1+count·P.
- `count`=0 → `done` at cycle 1.
- Strobes never overlap an `a_d` or `bus_oe` transition: both change only at A_SU/D_SU entry or on a return to IDLE/FIN.
- Reset mid-burst: all outputs return to reset values asynchronously, with no `done` pulse. `start` must be re-issued.

## Structure
- Shared package `rtc_bus_pkg`:
  - state enum;
  - default timing constants;
  - `RTC_ADDR_W`=8.
- Sub-module `rtc_phase_timer`:
  - loadable down-counter;
  - loads T_SU/T_PW/T_HD−1 on phase entry;
  - asserts `last` at zero.
- Top level holds the FSM, the address/index counters and the capture registers.

## Test plan
- Reset mid-burst: reset asserted during D_PW → `cs`/`rd`/`wr` return to 1 and `bus_oe` to 0 asynchronously, with no `done`. A following `start` runs normally.
- Single write, defaults: `base_addr`=8'h21, `count`=1, `wr_data`=8'h45 → `bus_out`=8'h21 with `a_d`=0 and `wr` low for 4 cycles, then `bus_out`=8'h45 with `a_d`=1 and `wr` low for 4 cycles; `done` at cycle 17.
- Read burst: `base_addr`=8'h21, `count`=3, bus model returns address XOR 8'hA5 → `rd_valid` three times with `rd_data` 8'h84, 8'h87, 8'h86 and `word_idx` 0, 1, 2. `bus_oe`=0 in all D_* states; `done` at cycle 49.
- Wrap: `base_addr`=8'hFF, `count`=2 → addresses 8'hFF then 8'h00.
- `count`=0 → `done` at cycle 1, `cs` never low. A second `start` during a burst → ignored, no change to the latched burst.
- Timing override T_SU=1, T_PW=1, T_HD=1: `count`=2 → strobes low for exactly 1 cycle, `done` at cycle 13.
